// File: rtl/lvds_pkg.sv
// lvds_pkg: shared types for the LVDS lane logic.
// pair_t is the differential pad pair; tx_state_e is the transmit link state.
package lvds_pkg;

   // Differential pair as seen by the pad ring: p is true, n is complement
   typedef struct packed {
      logic p;
      logic n;
   } pair_t;

   // Transmit link state: training burst in progress, or normal running
   typedef enum logic {
      TRAIN = 1'b0,
      RUN   = 1'b1
   } tx_state_e;

endpackage : lvds_pkg

// File: rtl/lvds_out.sv
// lvds_out: single-ended to differential output stage for one lane.
// Mode "True" models a native differential buffer. Mode "Emulated" models
// two single-ended drivers, one of them inverted. Both are purely combinational.
module lvds_out
   import lvds_pkg::*;
#(
   parameter Mode = "True"
) (
   input  logic  single,
   output pair_t pair
);

   generate
      if (Mode == "Emulated") begin : g_emulated
         // Two independent single-ended drivers, the n leg inverted
         assign pair.p = single;
         assign pair.n = ~single;
      end else begin : g_true
         // Native differential buffer drives both legs from one source
         assign pair = '{p: single, n: ~single};
      end
   endgenerate

endmodule : lvds_out

// File: rtl/lvds_tx_link.sv
// lvds_tx_link: transmit-side link controller for one LVDS lane.
// Takes words over valid/ready and shifts them out MSB-first, one bit per clock.
// After reset, and on train_req, it sends a burst of TrainWord before data.
// Slots with no offered data carry filler words.
// Optional build macro: LVDS_TX_PRBS_IDLE_EN makes filler slots carry PRBS7
// (x^7+x^6+1, seed 7'h7F) instead of IdleWord.
module lvds_tx_link
   import lvds_pkg::*;
#(
   parameter int               Width       = 8,
   parameter logic [Width-1:0] TrainWord   = 8'hA5,
   parameter int               TrainRepeat = 4,
   parameter logic [Width-1:0] IdleWord    = 8'h00,
   parameter                   Mode        = "True"
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             train_req,
   input  logic [Width-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             training_o,
   output pair_t            pair
);

   localparam int              BitW      = $clog2(Width);
   localparam int              TrW       = $clog2(TrainRepeat + 1);
   localparam logic [BitW-1:0] BitMax    = BitW'(Width - 1);
   localparam logic [TrW-1:0]  TrainFull = TrW'(TrainRepeat);
   localparam logic [TrW-1:0]  TrainNext = TrW'(TrainRepeat - 1);

   tx_state_e        state_q, state_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [TrW-1:0]   train_cnt_q, train_cnt_d;
   logic [Width-1:0] shift_q, shift_d;
   logic             train_pend_q, train_pend_d;
   logic             first_q;
   logic             boundary;
   logic             train_busy;
   logic [Width-1:0] idle_word;

`ifdef LVDS_TX_PRBS_IDLE_EN
   logic [6:0]       lfsr_q, lfsr_d;
   logic [6:0]       lfsr_adv;
   logic [Width-1:0] prbs_word;

   // Precompute the next Width PRBS7 bits and the LFSR value after them.
   // The first generated bit becomes the MSB, so it goes out on the wire first.
   always_comb begin
      logic fb;
      lfsr_adv  = lfsr_q;
      prbs_word = '0;
      for (int i = Width - 1; i >= 0; i--) begin
         fb           = lfsr_adv[6] ^ lfsr_adv[5];
         prbs_word[i] = fb;
         lfsr_adv     = {lfsr_adv[5:0], fb};
      end
   end

   // The LFSR only moves when a filler slot is actually loaded.
   // Data words therefore leave the PRBS sequence unbroken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 7'h7F;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign idle_word = prbs_word;
`else
   assign idle_word = IdleWord;
`endif

   // Boundary: the first cycle after reset, or the last bit of the current word.
   // Training words still owed, or a pending train request, block acceptance.
   always_comb begin
      boundary   = first_q || (bit_cnt_q == '0);
      train_busy = (state_q == TRAIN) && (train_cnt_q != '0);
      ready_o    = boundary && !train_pend_q && !train_busy;
      training_o = (state_q == TRAIN);
   end

   // Next-state logic.
   // Between boundaries, the word shifts left and the counter counts down.
   // At a boundary, the next word is picked in this order:
   //    1. the remaining training words,
   //    2. a new burst if one is pending,
   //    3. offered data,
   //    4. filler.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q - 1'b1;
      train_cnt_d  = train_cnt_q;
      shift_d      = {shift_q[Width-2:0], 1'b0};
      train_pend_d = train_pend_q;
`ifdef LVDS_TX_PRBS_IDLE_EN
      lfsr_d       = lfsr_q;
`endif
      if (boundary) begin
         bit_cnt_d = BitMax;
         if (train_busy) begin
            shift_d     = TrainWord;
            train_cnt_d = train_cnt_q - 1'b1;
         end else if (train_pend_q) begin
            state_d      = TRAIN;
            train_cnt_d  = TrainNext;
            shift_d      = TrainWord;
            train_pend_d = 1'b0;
         end else begin
            state_d = RUN;
            if (valid_i) begin
               shift_d = data_i;
            end else begin
               shift_d = idle_word;
`ifdef LVDS_TX_PRBS_IDLE_EN
               lfsr_d  = lfsr_adv;
`endif
            end
         end
      end
      // A request raised while running is remembered until the next boundary.
      // A request is ignored during a burst, and also in the cycle a burst starts.
      if (train_req && (state_q != TRAIN) && !(boundary && train_pend_q)) begin
         train_pend_d = 1'b1;
      end
   end

   // State registers. Reset abandons any partial word and restarts training.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= TRAIN;
         bit_cnt_q    <= BitMax;
         train_cnt_q  <= TrainFull;
         shift_q      <= '0;
         train_pend_q <= 1'b0;
         first_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         train_cnt_q  <= train_cnt_d;
         shift_q      <= shift_d;
         train_pend_q <= train_pend_d;
         first_q      <= 1'b0;
      end
   end

   lvds_out #(
      .Mode(Mode)
   ) u_out (
      .single(shift_q[Width-1]),
      .pair  (pair)
   );

endmodule : lvds_tx_link

// File: tb/tb_lvds_tx_link.sv
// tb_lvds_tx_link: directed, self-checking bench for lvds_tx_link at default
// parameters.
// Cycle 0 is the cycle in which reset is released. Inputs are driven and
// outputs are sampled on the falling clock edge.
module tb_lvds_tx_link;
   import lvds_pkg::*;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       train_req  = 1'b0;
   logic       valid_i    = 1'b0;
   logic [7:0] data_i     = 8'h00;
   logic       ready_o;
   logic       training_o;
   pair_t      pair;

   int          assertCount = 0;
   int          failCount   = 0;
   int          cyc         = 0;
   logic [31:0] stream;
   logic [15:0] s16;
   logic [7:0]  s8a, s8b;
   int          trainHigh, readyEarly, firstTrain, readyAt40;
   int          acc0, acc1, idx;
   bit          pendAdv;
   logic [7:0]  words [2];

`ifdef LVDS_TX_PRBS_IDLE_EN
   logic [6:0]  lfsrModel;
   logic [23:0] prbsExp, prbsObs;
   logic        fbModel;
   int          accP;
   bit          dropValid;
`endif

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   lvds_tx_link dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .train_req (train_req),
      .data_i    (data_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .training_o(training_o),
      .pair      (pair)
   );

   // Single comparison point: counts the check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   // Hold reset for two cycles with inputs idle, then release on a falling edge
   task automatic applyStimulus();
      rst_n     = 1'b0;
      train_req = 1'b0;
      valid_i   = 1'b0;
      data_i    = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      #1;
   endtask

   // Advance to the middle of the next cycle
   task automatic stepCycle();
      @(negedge clk);
      cyc++;
   endtask

   // Directed test sequence
   initial begin
      // ---- Reset release with no data: check the training burst, then filler
      applyStimulus();
      checkOutput("rst_p", pair.p, 0);
      checkOutput("rst_n_leg", pair.n, 1);
      checkOutput("rst_ready", ready_o, 0);
      checkOutput("rst_training", training_o, 1);
      stream = '0; trainHigh = 0; readyEarly = 0;
      for (int i = 1; i <= 32; i++) begin
         stepCycle();
         stream = {stream[30:0], pair.p};
         trainHigh += int'(training_o);
         if (i < 32) readyEarly += int'(ready_o);
      end
      checkOutput("t1_burst", stream, 32'hA5A5A5A5);
      checkOutput("t1_training_cycles", trainHigh, 32);
      checkOutput("t1_ready_before_32", readyEarly, 0);
      checkOutput("t1_ready_32", ready_o, 1);
      s8a = '0;
      for (int i = 33; i <= 40; i++) begin
         stepCycle();
         if (i == 33) checkOutput("t1_training_drop", training_o, 0);
         s8a = {s8a[6:0], pair.p};
      end
`ifndef LVDS_TX_PRBS_IDLE_EN
      checkOutput("t1_idle", s8a, 8'h00);
`endif

      // ---- Data offered from cycle 20: 3C should be accepted at 32, FF at 40
      applyStimulus();
      words = '{8'h3C, 8'hFF};
      idx = 0; pendAdv = 0; acc0 = -1; acc1 = -1; s16 = '0;
      for (int c = 1; c <= 48; c++) begin
         stepCycle();
         if (pendAdv) begin
            pendAdv = 0;
            idx++;
            if (idx < 2) data_i = words[idx];
            else valid_i = 1'b0;
         end
         if (c == 20) begin
            valid_i = 1'b1;
            data_i  = words[0];
         end
         if (c >= 33) s16 = {s16[14:0], pair.p};
         if (valid_i && ready_o) begin
            if (idx == 0) acc0 = c; else acc1 = c;
            pendAdv = 1;
         end
      end
      checkOutput("t2_accept_first", acc0, 32);
      checkOutput("t2_accept_second", acc1, 40);
      checkOutput("t2_serial", s16, 16'h3CFF);

      // ---- train_req at bit 3 of a data word, then a second request mid-burst
      applyStimulus();
      words = '{8'h3C, 8'h5A};
      idx = 0; pendAdv = 0; acc0 = -1; acc1 = -1;
      valid_i = 1'b1; data_i = words[0];
      s8a = '0; s8b = '0; stream = '0; trainHigh = 0; firstTrain = -1; readyAt40 = -1;
      for (int c = 1; c <= 96; c++) begin
         stepCycle();
         if (pendAdv) begin
            pendAdv = 0;
            idx++;
            if (idx < 2) data_i = words[idx];
            else valid_i = 1'b0;
         end
         train_req = (c == 37) || (c == 50);
         if (c >= 33 && c <= 40) s8a = {s8a[6:0], pair.p};
         if (c >= 41 && c <= 72) stream = {stream[30:0], pair.p};
         if (c >= 73 && c <= 80) s8b = {s8b[6:0], pair.p};
         if (c == 40) readyAt40 = int'(ready_o);
         if (c >= 33) begin
            trainHigh += int'(training_o);
            if (training_o && firstTrain < 0) firstTrain = c;
         end
         if (valid_i && ready_o) begin
            if (idx == 0) acc0 = c; else acc1 = c;
            pendAdv = 1;
         end
      end
      train_req = 1'b0;
      checkOutput("t3_accept_first", acc0, 32);
      checkOutput("t3_word_completes", s8a, 8'h3C);
      checkOutput("t3_ready_at_boundary", readyAt40, 0);
      checkOutput("t3_retrain_burst", stream, 32'hA5A5A5A5);
      checkOutput("t3_training_start", firstTrain, 41);
      checkOutput("t3_training_cycles", trainHigh, 32);
      checkOutput("t3_accept_after_train", acc1, 72);
      checkOutput("t3_data_after_train", s8b, 8'h5A);

      // ---- Reset asserted mid-word: output drops at once, training repeats
      applyStimulus();
      valid_i = 1'b1; data_i = 8'hFF;
      for (int c = 1; c <= 35; c++) stepCycle();
      checkOutput("t5_pre_reset_p", pair.p, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_async_p", pair.p, 0);
      checkOutput("t5_async_n", pair.n, 1);
      checkOutput("t5_async_training", training_o, 1);
      checkOutput("t5_async_ready", ready_o, 0);
      valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      stream = '0; s8a = '0; trainHigh = 0;
      for (int c = 1; c <= 40; c++) begin
         stepCycle();
         if (c <= 32) begin
            stream = {stream[30:0], pair.p};
            trainHigh += int'(training_o);
         end else begin
            s8a = {s8a[6:0], pair.p};
         end
      end
      checkOutput("t5_burst", stream, 32'hA5A5A5A5);
      checkOutput("t5_training_cycles", trainHigh, 32);
`ifndef LVDS_TX_PRBS_IDLE_EN
      checkOutput("t5_no_resend", s8a, 8'h00);
`endif

`ifdef LVDS_TX_PRBS_IDLE_EN
      // ---- PRBS filler: a data word interleaved mid-stream must not skip bits
      lfsrModel = 7'h7F;
      prbsExp   = '0;
      for (int k = 0; k < 24; k++) begin
         fbModel   = lfsrModel[6] ^ lfsrModel[5];
         prbsExp   = {prbsExp[22:0], fbModel};
         lfsrModel = {lfsrModel[5:0], fbModel};
      end
      applyStimulus();
      prbsObs = '0; s8a = '0; accP = -1; dropValid = 0;
      for (int c = 1; c <= 64; c++) begin
         stepCycle();
         if (dropValid) begin
            dropValid = 0;
            valid_i = 1'b0;
         end
         if (c == 45) begin
            valid_i = 1'b1;
            data_i  = 8'h3C;
         end
         if ((c >= 33 && c <= 48) || (c >= 57 && c <= 64))
            prbsObs = {prbsObs[22:0], pair.p};
         if (c >= 49 && c <= 56) s8a = {s8a[6:0], pair.p};
         if (valid_i && ready_o) begin
            accP = c;
            dropValid = 1;
         end
      end
      checkOutput("prbs_accept", accP, 48);
      checkOutput("prbs_data", s8a, 8'h3C);
      checkOutput("prbs_idle_bits", prbsObs, prbsExp);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule : tb_lvds_tx_link
